imem_program_loader: RTL and testbench
======================================

Name: imem_program_loader

Overview:
- Reverse side of the instruction decode path: writes the instruction words that the controller later decodes.
- Receives a byte stream over a valid/ready interface, packs bytes MSB-first into 32-bit instruction words and writes them into instruction memory starting at address 0.
- Checks each word's opcode field against a legal-opcode mask and holds the CPU core stalled while a load is in progress or has failed.

Parameters:
- ADDR_WIDTH, 8: instruction memory word-address width. Depth is 2^ADDR_WIDTH words.
- OP_LSB, 26: bit position of the 6-bit opcode field in an instruction word. Opcode is word[OP_LSB+5:OP_LSB].
- VALID_OP_MASK, 64'hFFFF_FFFF_FFFF_FFFF: bit k set means opcode k is legal.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts a byte; transfer occurs when in_valid & in_ready
- im_we  out  1  instruction memory write enable, registered
- im_addr  out  ADDR_WIDTH  instruction memory word address, registered
- im_wdata  out  32  instruction word, registered
- cpu_hold  out  1  stalls the CPU core
- busy  out  1  load in progress
- done  out  1  load completed successfully; sticky until next start or rst
- error  out  1  load aborted; sticky until next start or rst
- err_code  out  2  0 none, 1 illegal opcode, 2 length overflow, 3 checksum mismatch
- err_addr  out  ADDR_WIDTH  word address at which the load aborted
- word_cnt  out  16  words written so far

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE; in_ready, im_we, busy, done, error = 0; im_addr, im_wdata, err_code, err_addr, word_cnt = 0; cpu_hold = 0.
- Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4*N instruction bytes, MSB first.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHK (present only with the optional feature), DONE, ERROR.
- IDLE/DONE/ERROR:
  - in_ready = 0.
  - On start: clear done, error, err_code, word_cnt, the address counter and the byte index; go to LEN_HI.
- LEN_HI: in_ready = 1; on transfer, capture len[15:8] and go to LEN_LO.
- LEN_LO: in_ready = 1; on transfer, capture len[7:0], then:
  - N == 0: go to DONE.
  - N > 2^ADDR_WIDTH: go to ERROR, err_code = 2, err_addr = 0.
  - Otherwise: go to DATA.
- DATA:
  - in_ready = 1; on each transfer, shift the word left 8 and insert in_data.
  - On the 4th byte, go to WRITE and reset the byte index.
- WRITE (exactly 1 cycle), in_ready = 0:
  - Illegal opcode (VALID_OP_MASK bit clear): im_we stays 0, go to ERROR, err_code = 1, err_addr = current address.
  - Legal opcode: im_we = 1 with im_addr = current address and im_wdata = packed word, then increment address and word_cnt.
    - word_cnt == N after the increment: go to DONE (or CHK when the feature is enabled).
    - Otherwise: return to DATA.
- im_we is high for exactly one cycle per written word and is never high outside WRITE.
- Throughput: minimum 5 cycles per word (4 byte transfers + 1 WRITE).
- Address counter: ADDR_WIDTH+1 bits internally. Writing the full depth is legal; the address never wraps.
- busy = 1 in LEN_HI, LEN_LO, DATA, WRITE, CHK.
- cpu_hold = busy | error. CPU is released only after a successful load.
- start while busy is ignored. in_valid while in_ready = 0 is ignored; no byte is consumed.
- rst mid-load: returns immediately to reset values. Words already written stay in memory; done = 0.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, go to CHK (in_ready = 1) and accept one byte: the XOR of all 4*N data bytes.
  - Match: go to DONE. Mismatch: go to ERROR, err_code = 3, err_addr = N-1.
  - When N == 0, the checksum byte (0x00) is still required.
- Undefined: no CHK state, no checksum byte, err_code 3 never produced.

Test Plan:
- Reset, start, stream 00 02 20 01 00 05 8C 02 00 00 (legal opcodes) -> im_we pulses at addr 0 with 0x20010005 and at addr 1 with 0x8C020000; done = 1, cpu_hold = 0, word_cnt = 2.
- VALID_OP_MASK bit 0x3F clear; stream 00 02, word 0x20010005, word 0xFC000000 -> first word written; no write at addr 1; error = 1, err_code = 1, err_addr = 1, cpu_hold = 1.
- ADDR_WIDTH = 8, length 01 01 (257) -> ERROR, err_code = 2, no im_we; a new start clears error.
- Toggle in_valid randomly mid-word, plus start asserted during DATA -> word contents unchanged, start ignored, in_ready low in WRITE.
- rst asserted after 2 bytes of word 1 -> all outputs at reset values next cycle; a subsequent full load succeeds.
- LOADER_CHECKSUM_EN: stream 00 01 12 34 56 78, checksum 0x08 -> done; checksum 0x09 -> err_code = 3, err_addr = 0.

Source files
------------

// File: rtl/imem_program_loader_if.sv
// imem_program_loader_if: byte-stream input and instruction-memory write bus of the program loader.
// Signals:
//   in_data/in_valid  stream byte and its valid, driven by the byte source
//   in_ready          loader accepts a byte; a transfer is in_valid & in_ready
//   im_we/im_addr/im_wdata  one-cycle word write into instruction memory
// Modports: master = loader side, slave = environment (byte source + memory).
interface imem_program_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  im_we;
    logic [ADDR_WIDTH-1:0] im_addr;
    logic [31:0]           im_wdata;
    modport master (
        input  in_data, in_valid,
        output in_ready, im_we, im_addr, im_wdata
    );
    modport slave (
        output in_data, in_valid,
        input  in_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/imem_program_loader.sv
// imem_program_loader: packs a length-prefixed byte stream MSB-first into 32-bit words,
// writes them to instruction memory from address 0, vets opcodes and stalls the CPU meanwhile.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start_i       one-cycle pulse beginning a load (honoured in IDLE, DONE, ERROR)
//   bus           stream input and memory write bus (imem_program_loader_if.master)
//   cpu_hold_o    CPU stall, busy_o | error_o
//   busy_o        load in progress
//   done_o        sticky success flag
//   error_o       sticky abort flag
//   err_code_o    0 none, 1 illegal opcode, 2 length overflow, 3 checksum mismatch
//   err_addr_o    word address at which the load aborted
//   word_cnt_o    words written so far
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_program_loader #(
    parameter int          ADDR_WIDTH    = 8,
    parameter int          OP_LSB        = 26,
    parameter logic [63:0] VALID_OP_MASK = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    imem_program_loader_if.master bus,
    output logic                  cpu_hold_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [1:0]            err_code_o,
    output logic [ADDR_WIDTH-1:0] err_addr_o,
    output logic [15:0]           word_cnt_o
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    // S_FIN is where a load goes once all words are written; with the checksum
    // it still needs one more byte, so it stays busy and ready.
`ifdef LOADER_CHECKSUM_EN
    localparam bit     CSUM  = 1'b1;
    localparam state_t S_FIN = S_CHK;
`else
    localparam bit     CSUM  = 1'b0;
    localparam state_t S_FIN = S_DONE;
`endif

    // One extra bit so that writing the full depth never wraps the counter.
    localparam int CW = ADDR_WIDTH + 1;

    state_t                state_q;
    logic [15:0]           len_q;
    logic [15:0]           word_cnt_q;
    logic [31:0]           word_q;
    logic [1:0]            bidx_q;
    logic [CW-1:0]         addr_q;
    logic                  in_ready_q;
    logic                  im_we_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;
    logic [1:0]            err_code_q;
    logic [ADDR_WIDTH-1:0] err_addr_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            csum_q;
`endif

    logic        xfer;
    logic [31:0] word_d;
    logic [15:0] len_d;
    logic [15:0] cnt_d;
    logic        op_ok_d;
    logic        op_ok_q;
    logic        too_long;

    assign xfer     = bus.in_valid & in_ready_q;
    assign word_d   = {word_q[23:0], bus.in_data};
    assign len_d    = {len_q[15:8], bus.in_data};
    assign cnt_d    = word_cnt_q + 16'd1;
    assign op_ok_d  = VALID_OP_MASK[word_d[OP_LSB +: 6]];
    assign op_ok_q  = VALID_OP_MASK[word_q[OP_LSB +: 6]];
    assign too_long = {1'b0, len_d} > (17'd1 << ADDR_WIDTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            word_q     <= '0;
            bidx_q     <= '0;
            addr_q     <= '0;
            in_ready_q <= 1'b0;
            im_we_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= '0;
            err_addr_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start_i) begin
                        state_q    <= S_LEN_HI;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        err_code_q <= '0;
                        word_cnt_q <= '0;
                        addr_q     <= '0;
                        bidx_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum_q     <= '0;
`endif
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        len_q[15:8] <= bus.in_data;
                        state_q     <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        len_q[7:0] <= bus.in_data;
                        if (len_d == 16'd0) begin
                            state_q    <= S_FIN;
                            in_ready_q <= CSUM;
                            busy_q     <= CSUM;
                            done_q     <= !CSUM;
                        end else if (too_long) begin
                            state_q    <= S_ERROR;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            error_q    <= 1'b1;
                            err_code_q <= 2'd2;
                            err_addr_q <= '0;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        word_q <= word_d;
                        bidx_q <= bidx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ bus.in_data;
`endif
                        // The write strobe is decided here so it is a registered
                        // pulse aligned with the single WRITE cycle.
                        if (bidx_q == 2'd3) begin
                            state_q    <= S_WRITE;
                            in_ready_q <= 1'b0;
                            im_we_q    <= op_ok_d;
                        end
                    end
                end
                S_WRITE: begin
                    im_we_q <= 1'b0;
                    if (!op_ok_q) begin
                        state_q    <= S_ERROR;
                        busy_q     <= 1'b0;
                        error_q    <= 1'b1;
                        err_code_q <= 2'd1;
                        err_addr_q <= addr_q[ADDR_WIDTH-1:0];
                    end else begin
                        addr_q     <= addr_q + CW'(1);
                        word_cnt_q <= cnt_d;
                        if (cnt_d == len_q) begin
                            state_q    <= S_FIN;
                            in_ready_q <= CSUM;
                            busy_q     <= CSUM;
                            done_q     <= !CSUM;
                        end else begin
                            state_q    <= S_DATA;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (xfer) begin
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        if (bus.in_data == csum_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= S_ERROR;
                            error_q    <= 1'b1;
                            err_code_q <= 2'd3;
                            err_addr_q <= ADDR_WIDTH'(len_q - 16'd1);
                        end
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // addr_q holds the current word address during WRITE and word_q the packed word.
    assign bus.in_ready = in_ready_q;
    assign bus.im_we    = im_we_q;
    assign bus.im_addr  = addr_q[ADDR_WIDTH-1:0];
    assign bus.im_wdata = word_q;
    assign cpu_hold_o   = busy_q | error_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign err_code_o   = err_code_q;
    assign err_addr_o   = err_addr_q;
    assign word_cnt_o   = word_cnt_q;
endmodule

// File: tb/tb_imem_program_loader.sv
// tb_imem_program_loader: directed scoreboard bench for imem_program_loader.
module tb_imem_program_loader;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          cpu_hold, busy, done, error;
    logic [1:0]    err_code;
    logic [AW-1:0] err_addr;
    logic [15:0]   word_cnt;
    int            total = 0;
    int            bad = 0;
    bit            bubbles = 1'b0;
    logic [AW+31:0] exp_q[$];
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    csum = 8'h00;
`endif

    imem_program_loader_if #(.ADDR_WIDTH(AW)) bus ();

    imem_program_loader #(
        .ADDR_WIDTH(AW),
        .OP_LSB(26),
        .VALID_OP_MASK(64'h7FFF_FFFF_FFFF_FFFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_i(start),
        .bus(bus),
        .cpu_hold_o(cpu_hold),
        .busy_o(busy),
        .done_o(done),
        .error_o(error),
        .err_code_o(err_code),
        .err_addr_o(err_addr),
        .word_cnt_o(word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe is matched against the next expected write.
    always @(negedge clk) begin
        if (!rst && bus.im_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", bus.im_addr, bus.im_wdata);
            end else begin
                check("write_addr_data", {bus.im_addr, bus.im_wdata}, exp_q.pop_front());
            end
            check("ready_low_in_write", 32'(bus.in_ready), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        if (bubbles)
            repeat ($urandom_range(0, 2)) begin
                bus.in_valid = 1'b0;
                bus.in_data = 8'($urandom);
                tick();
            end
        bus.in_data = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got in_ready 0 expected 1");
        end else begin
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[i*8 +: 8]);
`ifdef LOADER_CHECKSUM_EN
            csum = csum ^ w[i*8 +: 8];
`endif
        end
    endtask

    task automatic send_csum();
`ifdef LOADER_CHECKSUM_EN
        send_byte(csum);
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum = 8'h00;
`endif
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done || error) && n < 100) begin
            tick();
            n++;
        end
        if (!(done || error)) begin
            total++;
            bad++;
            $display("FAIL end_timeout: got done 0 error 0 expected one set");
        end
    endtask

    task automatic expect_ok(input logic [15:0] cnt);
        check("done", 32'(done), 32'd1);
        check("error", 32'(error), 32'd0);
        check("cpu_hold", 32'(cpu_hold), 32'd0);
        check("busy", 32'(busy), 32'd0);
        check("word_cnt", 32'(word_cnt), 32'(cnt));
        check("pending_writes", exp_q.size(), 32'd0);
    endtask

    task automatic expect_err(input logic [1:0] code, input logic [AW-1:0] addr, input logic [15:0] cnt);
        check("error", 32'(error), 32'd1);
        check("done", 32'(done), 32'd0);
        check("err_code", 32'(err_code), 32'(code));
        check("err_addr", 32'(err_addr), 32'(addr));
        check("cpu_hold", 32'(cpu_hold), 32'd1);
        check("word_cnt", 32'(word_cnt), 32'(cnt));
        check("pending_writes", exp_q.size(), 32'd0);
    endtask

    task automatic check_reset_vals();
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_im_we", 32'(bus.im_we), 32'd0);
        check("rst_im_addr", 32'(bus.im_addr), 32'd0);
        check("rst_im_wdata", bus.im_wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_err_addr", 32'(err_addr), 32'd0);
        check("rst_word_cnt", 32'(word_cnt), 32'd0);
    endtask

    task automatic load_one();
        pulse_start();
        exp_q.push_back({8'd0, 32'h0400_0001});
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'h0400_0001);
        send_csum();
        wait_end();
        expect_ok(16'd1);
    endtask

    initial begin
        bus.in_data = 8'h00;
        bus.in_valid = 1'b0;
        repeat (3) tick();
        check_reset_vals();
        rst = 1'b0;
        tick();

        // Two legal words.
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        check("hold_after_start", 32'(cpu_hold), 32'd1);
        exp_q.push_back({8'd0, 32'h2001_0005});
        exp_q.push_back({8'd1, 32'h8C02_0000});
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(32'h2001_0005);
        send_word(32'h8C02_0000);
        send_csum();
        wait_end();
        expect_ok(16'd2);

        // Illegal opcode 0x3F in the second word.
        pulse_start();
        check("done_cleared", 32'(done), 32'd0);
        exp_q.push_back({8'd0, 32'h2001_0005});
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(32'h2001_0005);
        send_word(32'hFC00_0000);
        wait_end();
        expect_err(2'd1, 8'd1, 16'd1);

        // Length 257 overflows a 256-word memory.
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        wait_end();
        expect_err(2'd2, 8'd0, 16'd0);
        tick();
        pulse_start();
        check("error_cleared", 32'(error), 32'd0);
        check("err_code_cleared", 32'(err_code), 32'd0);
        exp_q.push_back({8'd0, 32'h0400_0001});
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'h0400_0001);
        send_csum();
        wait_end();
        expect_ok(16'd1);

        // Zero-length load.
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        send_csum();
        wait_end();
        expect_ok(16'd0);

        // Bubbles on in_valid and a start pulse mid-word that must be ignored.
        bubbles = 1'b1;
        pulse_start();
        exp_q.push_back({8'd0, 32'h1234_5678});
        exp_q.push_back({8'd1, 32'hDEAD_BEEF});
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
`ifdef LOADER_CHECKSUM_EN
        csum = 8'h12 ^ 8'h34;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ignored_busy", 32'(busy), 32'd1);
        check("start_ignored_ready", 32'(bus.in_ready), 32'd1);
        send_byte(8'h56);
        send_byte(8'h78);
`ifdef LOADER_CHECKSUM_EN
        csum = csum ^ 8'h56 ^ 8'h78;
`endif
        send_word(32'hDEAD_BEEF);
        send_csum();
        bubbles = 1'b0;
        wait_end();
        expect_ok(16'd2);

        // Reset in the middle of the first word.
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst = 1'b1;
        tick();
        check_reset_vals();
        rst = 1'b0;
        tick();
        load_one();

        // Full depth: 256 words, last address 255, no wrap.
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back({8'(i), 32'h0400_0000 | 32'(i)});
            send_word(32'h0400_0000 | 32'(i));
        end
        send_csum();
        wait_end();
        expect_ok(16'd256);

`ifdef LOADER_CHECKSUM_EN
        // XOR of 12 34 56 78 is 08.
        pulse_start();
        exp_q.push_back({8'd0, 32'h1234_5678});
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'h1234_5678);
        send_byte(8'h08);
        wait_end();
        expect_ok(16'd1);
        pulse_start();
        exp_q.push_back({8'd0, 32'h1234_5678});
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'h1234_5678);
        send_byte(8'h09);
        wait_end();
        check("error", 32'(error), 32'd1);
        check("err_code", 32'(err_code), 32'd3);
        check("err_addr", 32'(err_addr), 32'd0);
        check("word_cnt", 32'(word_cnt), 32'd1);
        check("pending_writes", exp_q.size(), 32'd0);
`endif

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
